// File: rtl/ysyx_22040895_exu_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencer: datapath width, timeout default,
// FSM state encoding, access size codes and the alignment helper.
package ysyx_22040895_exu_ctrl_pkg;

  localparam int XLEN             = 64;
  localparam int TIMEOUT_CYC_DEF  = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_WB       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // An access is aligned when the byte offset is a multiple of its size in bytes.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return |(off & m);
  endfunction

endpackage

// File: rtl/ysyx_22040895_exu_ctrl_if.sv
// Bundle of the three handshakes around the sequencer: IDU/EXU packet in, memory
// request/response, writeback packet out, plus the sticky error flag.
interface ysyx_22040895_exu_ctrl_if;
  import ysyx_22040895_exu_ctrl_pkg::*;

  // Every channel is valid/ready: a transfer happens on a rising edge where both are 1;
  // the sender keeps valid and its payload stable until that edge. mem_rsp_valid is a
  // one-cycle pulse with no back-pressure.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] in_mdata;
  logic            in_ld;
  logic            in_st;
  logic [1:0]      in_size;
  logic            in_unsigned;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic            in_jump;
  logic [XLEN-1:0] in_dnpc;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_wmask;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;

  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_npc;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;

  logic            err;

  // slave: the sequencer itself; master: the surrounding pipeline, memory and WBU.
  modport slave (
    input  in_valid, in_pc, in_result, in_mdata, in_ld, in_st, in_size, in_unsigned,
           in_rd, in_rd_we, in_jump, in_dnpc,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, wb_ready,
    output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
           wb_valid, wb_pc, wb_npc, wb_rd, wb_we, wb_data, err
  );

  modport master (
    output in_valid, in_pc, in_result, in_mdata, in_ld, in_st, in_size, in_unsigned,
           in_rd, in_rd_we, in_jump, in_dnpc,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, wb_ready,
    input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
           wb_valid, wb_pc, wb_npc, wb_rd, wb_we, wb_data, err
  );

endinterface

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational byte-lane logic: store data/strobe placement within the 64-bit word and
// load data extraction with zero/sign extension.
module ysyx_22040895_lsu_align
  import ysyx_22040895_exu_ctrl_pkg::*;
(
  input  logic [2:0]      st_off,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_wmask,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [2:0]      ld_off,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]      base_mask;
  logic [XLEN-1:0] ld_sh;

  always_comb begin
    case (st_size)
      SZ_B:    base_mask = 8'h01;
      SZ_H:    base_mask = 8'h03;
      SZ_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    st_wmask = base_mask << st_off;
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_sh = ld_rdata >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                                  : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      SZ_H: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                                  : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      SZ_W: ld_data = ld_unsigned ? {{(XLEN-32){1'b0}}, ld_sh[31:0]}
                                  : {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_exu_ctrl.sv
// Execute-stage sequencer: takes one packet per handshake, runs the memory access for
// loads/stores with a response timeout, and presents one writeback packet to WBU.
module ysyx_22040895_exu_ctrl
  import ysyx_22040895_exu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040895_exu_ctrl_if.slave  bus,
  output state_t                   dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            err_q;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc_q;
  logic [XLEN-1:0] data_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic            rd_we_q;
  logic            is_st_q;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic            req_we_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] req_wdata_q;
  logic [7:0]      req_wmask_q;

  logic [XLEN-1:0] st_wdata;
  logic [7:0]      st_wmask;
  logic [XLEN-1:0] ld_data;
  logic            in_mem;
  logic            in_wr;

  assign in_mem = bus.in_ld | bus.in_st;
  assign in_wr  = bus.in_rd_we & (bus.in_rd != 5'd0);

  // Store lanes come from the live inputs at accept; load extraction uses the latched
  // offset/size against the response word.
  ysyx_22040895_lsu_align u_align (
    .st_off      (bus.in_result[2:0]),
    .st_size     (bus.in_size),
    .st_data     (bus.in_mdata),
    .st_wdata    (st_wdata),
    .st_wmask    (st_wmask),
    .ld_rdata    (bus.mem_rsp_rdata),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      err_q       <= 1'b0;
      pc_q        <= '0;
      npc_q       <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      rd_we_q     <= 1'b0;
      is_st_q     <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            pc_q    <= bus.in_pc;
            npc_q   <= bus.in_jump ? bus.in_dnpc : bus.in_pc + XLEN'(4);
            rd_q    <= bus.in_rd;
            rd_we_q <= in_wr;
            is_st_q <= bus.in_st;
            off_q   <= bus.in_result[2:0];
            size_q  <= bus.in_size;
            uns_q   <= bus.in_unsigned;
            if (!in_mem) begin
              data_q <= bus.in_result;
              we_q   <= in_wr;
              state  <= ST_WB;
            end else if (misaligned(bus.in_result[2:0], bus.in_size)) begin
              // Faulting access never reaches memory; it retires as a no-write packet.
              data_q <= '0;
              we_q   <= 1'b0;
              err_q  <= 1'b1;
              state  <= ST_WB;
            end else begin
              data_q      <= '0;
              we_q        <= 1'b0;
              req_we_q    <= bus.in_st;
              req_addr_q  <= {bus.in_result[XLEN-1:3], 3'b000};
              req_wdata_q <= st_wdata;
              req_wmask_q <= st_wmask;
              state       <= ST_MEM_REQ;
            end
          end
        end

        ST_MEM_REQ: begin
          if (bus.mem_req_ready) begin
            cnt <= '0;
            if (bus.mem_rsp_valid) begin
              data_q <= is_st_q ? '0 : ld_data;
              we_q   <= ~is_st_q & rd_we_q;
              state  <= ST_WB;
            end else begin
              state <= ST_MEM_WAIT;
            end
          end
        end

        ST_MEM_WAIT: begin
          if (bus.mem_rsp_valid) begin
            data_q <= is_st_q ? '0 : ld_data;
            we_q   <= ~is_st_q & rd_we_q;
            state  <= ST_WB;
          end else if (cnt == CW'(TIMEOUT_CYC)) begin
            // Give up on the response; anything arriving later is dropped outside this state.
            data_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b1;
            state  <= ST_WB;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_WB: begin
          if (bus.wb_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state == ST_IDLE);
  assign bus.mem_req_valid = (state == ST_MEM_REQ);
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.wb_valid      = (state == ST_WB);
  assign bus.wb_pc         = pc_q;
  assign bus.wb_npc        = npc_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_we         = we_q;
  assign bus.wb_data       = data_q;
  assign bus.err           = err_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_ysyx_22040895_exu_ctrl.sv
// Bench for the execute-stage sequencer: directed corner cases plus randomized packets,
// scored against a byte-level reference model of loads, stores and next-pc.
module tb_ysyx_22040895_exu_ctrl;
  import ysyx_22040895_exu_ctrl_pkg::*;

  localparam int W = 3*XLEN + 7;  // {pc, npc, data, rd, we, data_checked}

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg_state;

  ysyx_22040895_exu_ctrl_if bus();

  ysyx_22040895_exu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic           err_exp  = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] rdata, input int off,
                                               input int size, input bit uns);
    int              nb;
    logic [XLEN-1:0] v;
    logic [XLEN-1:0] mask;
    nb = 1 << size;
    v  = rdata >> (8 * off);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_wmask(input int off, input int size);
    return 8'(((1 << (1 << size)) - 1) << off);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_result     = '0;
    bus.in_mdata      = '0;
    bus.in_ld         = 1'b0;
    bus.in_st         = 1'b0;
    bus.in_size       = 2'd0;
    bus.in_unsigned   = 1'b0;
    bus.in_rd         = 5'd0;
    bus.in_rd_we      = 1'b0;
    bus.in_jump       = 1'b0;
    bus.in_dnpc       = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.wb_ready      = 1'b0;
  endtask

  // After accept the packet inputs are junk; the DUT must have latched what it needs.
  task automatic scramble_inputs();
    bus.in_pc       = {$urandom, $urandom};
    bus.in_result   = {$urandom, $urandom};
    bus.in_mdata    = {$urandom, $urandom};
    bus.in_ld       = 1'($urandom);
    bus.in_st       = ~bus.in_ld;
    bus.in_size     = 2'($urandom);
    bus.in_unsigned = 1'($urandom);
    bus.in_rd       = 5'($urandom);
    bus.in_rd_we    = 1'($urandom);
    bus.in_jump     = 1'($urandom);
    bus.in_dnpc     = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  XLEN'(bus.in_ready), 64'd1);
    check({tag, "_state"},     XLEN'(dbg_state), XLEN'(ST_IDLE));
    check({tag, "_req_valid"}, XLEN'(bus.mem_req_valid), 64'd0);
    check({tag, "_req_we"},    XLEN'(bus.mem_req_we), 64'd0);
    check({tag, "_req_addr"},  bus.mem_req_addr, 64'd0);
    check({tag, "_req_wdata"}, bus.mem_req_wdata, 64'd0);
    check({tag, "_req_wmask"}, XLEN'(bus.mem_req_wmask), 64'd0);
    check({tag, "_wb_valid"},  XLEN'(bus.wb_valid), 64'd0);
    check({tag, "_wb_pc"},     bus.wb_pc, 64'd0);
    check({tag, "_wb_npc"},    bus.wb_npc, 64'd0);
    check({tag, "_wb_rd"},     XLEN'(bus.wb_rd), 64'd0);
    check({tag, "_wb_we"},     XLEN'(bus.wb_we), 64'd0);
    check({tag, "_wb_data"},   bus.wb_data, 64'd0);
    check({tag, "_err"},       XLEN'(bus.err), 64'd0);
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store
  task automatic run_txn(input int kind, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] result,
                         input logic [XLEN-1:0] mdata, input logic [XLEN-1:0] rdata,
                         input int size, input bit uns, input logic [4:0] rd, input bit rd_we,
                         input bit jump, input logic [XLEN-1:0] dnpc,
                         input int req_stall, input int rsp_delay, input bit same_rsp,
                         input int wb_stall, input bit no_rsp);
    logic [XLEN-1:0] exp_npc, exp_data, exp_addr, exp_wdata;
    logic [7:0]      exp_wmask;
    logic [W-1:0]    pkt;
    bit              mem, mis, exp_we, chk_data, rsp_now;
    int              off, lat;

    off      = int'(result[2:0]);
    mem      = (kind != 0);
    mis      = mem && ((off % (1 << size)) != 0);
    exp_npc  = jump ? dnpc : pc + 64'd4;
    exp_we   = rd_we && (rd != 5'd0) && ((kind == 0) || (kind == 1 && !mis && !no_rsp));
    chk_data = (kind == 0) || (no_rsp && !mis) || (kind == 1 && !mis);
    exp_data = (kind == 0) ? result : (no_rsp ? 64'd0 : ref_load(rdata, off, size, uns));
    if (mis || no_rsp) err_exp = 1'b1;
    exp_q.push_back({pc, exp_npc, exp_data, rd, exp_we, chk_data});

    @(negedge clk);
    check("in_ready_idle", XLEN'(bus.in_ready), 64'd1);
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_result   = result;
    bus.in_mdata    = mdata;
    bus.in_ld       = (kind == 1);
    bus.in_st       = (kind == 2);
    bus.in_size     = 2'(size);
    bus.in_unsigned = uns;
    bus.in_rd       = rd;
    bus.in_rd_we    = rd_we;
    bus.in_jump     = jump;
    bus.in_dnpc     = dnpc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();

    if (mem && !mis) begin
      exp_addr  = {result[XLEN-1:3], 3'b000};
      exp_wdata = mdata << (8 * off);
      exp_wmask = ref_wmask(off, size);
      rsp_now   = same_rsp && !no_rsp;
      for (int i = 0; i <= req_stall; i++) begin
        check("mem_req_valid", XLEN'(bus.mem_req_valid), 64'd1);
        check("mem_req_addr",  bus.mem_req_addr, exp_addr);
        check("mem_req_we",    XLEN'(bus.mem_req_we), XLEN'(kind == 2));
        if (kind == 2) begin
          check("mem_req_wdata", bus.mem_req_wdata, exp_wdata);
          check("mem_req_wmask", XLEN'(bus.mem_req_wmask), XLEN'(exp_wmask));
        end
        if (i == req_stall) begin
          bus.mem_req_ready = 1'b1;
          if (rsp_now) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = rdata;
          end
        end
        @(negedge clk);
      end
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = {$urandom, $urandom};
      if (!rsp_now && !no_rsp) begin
        for (int i = 0; i < rsp_delay; i++) begin
          check("no_dup_req", XLEN'(bus.mem_req_valid), 64'd0);
          @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = {$urandom, $urandom};
      end
    end else begin
      check("no_mem_req", XLEN'(bus.mem_req_valid), 64'd0);
    end

    lat = 0;
    while (!bus.wb_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("wb_valid_seen", XLEN'(bus.wb_valid), 64'd1);
    if (no_rsp && mem && !mis)
      check("timeout_latency", XLEN'(lat >= TIMEOUT_CYC_DEF && lat <= TIMEOUT_CYC_DEF + 2), 64'd1);
    else
      check("wb_latency", XLEN'(lat), 64'd0);

    pkt = exp_q.pop_front();
    for (int i = 0; i <= wb_stall; i++) begin
      check("wb_valid",  XLEN'(bus.wb_valid), 64'd1);
      check("wb_pc",     bus.wb_pc, pkt[198:135]);
      check("wb_npc",    bus.wb_npc, pkt[134:71]);
      check("wb_rd",     XLEN'(bus.wb_rd), XLEN'(pkt[6:2]));
      check("wb_we",     XLEN'(bus.wb_we), XLEN'(pkt[1]));
      if (pkt[0]) check("wb_data", bus.wb_data, pkt[70:7]);
      check("err",       XLEN'(bus.err), XLEN'(err_exp));
      check("wb_no_req", XLEN'(bus.mem_req_valid), 64'd0);
      if (no_rsp && i == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = {$urandom, $urandom};
      end
      if (i == wb_stall) bus.wb_ready = 1'b1;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
    end
    bus.wb_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [XLEN-1:0] pc, res;
    int              kind, size;

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // ALU op, latency 1
    run_txn(0, 64'h8000_0000, 64'd5, 64'd0, 64'd0, 0, 1'b0, 5'd3, 1'b1, 1'b0, 64'd0,
            0, 0, 1'b0, 0, 1'b0);
    // ALU with jump and rd==0
    run_txn(0, 64'h8000_0010, 64'h1234, 64'd0, 64'd0, 0, 1'b0, 5'd0, 1'b1, 1'b1, 64'h8000_0400,
            0, 0, 1'b0, 1, 1'b0);
    // lb / lbu at offset 5
    run_txn(1, 64'h8000_0020, 64'h8000_1005, 64'd0, 64'h0000_80FF_0000_0000, 0, 1'b0, 5'd5, 1'b1,
            1'b0, 64'd0, 0, 1, 1'b0, 0, 1'b0);
    run_txn(1, 64'h8000_0024, 64'h8000_1005, 64'd0, 64'h0000_80FF_0000_0000, 0, 1'b1, 5'd6, 1'b1,
            1'b0, 64'd0, 0, 0, 1'b0, 0, 1'b0);
    // sh at offset 6
    run_txn(2, 64'h8000_0028, 64'h8000_1006, 64'hABCD, 64'd0, 1, 1'b0, 5'd7, 1'b1,
            1'b0, 64'd0, 0, 2, 1'b0, 0, 1'b0);
    // request held off 5 cycles, writeback held off 3 cycles
    run_txn(1, 64'h8000_002C, 64'h8000_2010, 64'd0, 64'hFEDC_BA98_7654_3210, 2, 1'b0, 5'd9, 1'b1,
            1'b0, 64'd0, 5, 2, 1'b0, 3, 1'b0);
    // response in the same cycle as request acceptance
    run_txn(1, 64'h8000_0030, 64'h8000_2018, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 5'd10, 1'b1,
            1'b0, 64'd0, 1, 0, 1'b1, 0, 1'b0);
    // pc+4 wraps
    run_txn(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd77, 64'd0, 64'd0, 0, 1'b0, 5'd1, 1'b1, 1'b0, 64'd0,
            0, 0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(0, 2));
      size = int'($urandom_range(0, 3));
      res  = {$urandom, $urandom};
      if (kind != 0) res = res & ~((64'd1 << size) - 64'd1);
      pc   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      run_txn(kind, pc, res, {$urandom, $urandom}, {$urandom, $urandom}, size,
              1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 1'b0);
    end

    // misaligned sd: no memory traffic, err becomes sticky
    run_txn(2, 64'h8000_0100, 64'h8000_1003, 64'h55, 64'd0, 3, 1'b0, 5'd4, 1'b1, 1'b0, 64'd0,
            0, 0, 1'b0, 1, 1'b0);
    // response never arrives: timeout, late response ignored
    run_txn(1, 64'h8000_0104, 64'h8000_3000, 64'd0, 64'd0, 3, 1'b0, 5'd8, 1'b1, 1'b0, 64'd0,
            0, 0, 1'b0, 2, 1'b1);

    // reset while waiting for a response
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_ld     = 1'b1;
    bus.in_st     = 1'b0;
    bus.in_result = 64'h8000_4000;
    bus.in_size   = 2'd3;
    bus.in_rd     = 5'd11;
    bus.in_rd_we  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_seq_req", XLEN'(bus.mem_req_valid), 64'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_seq_wait", XLEN'(dbg_state), XLEN'(ST_MEM_WAIT));
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid_wait");
    @(negedge clk);
    rst = 1'b1;
    err_exp = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("post_rst");

    run_txn(0, 64'h8000_0200, 64'hDEAD_BEEF, 64'd0, 64'd0, 0, 1'b0, 5'd12, 1'b1, 1'b0, 64'd0,
            0, 0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
